// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fetch_ctrl
// Brief    : Generates the PC-control strobes for fetch_unit. Handles boot,
//            redirects, interrupt entry and instruction-cache miss timeout.
// Revision : 1.0  initial release
// ============================================================================
module fetch_ctrl #(
    parameter logic [15:0] RESET_VECTOR = 16'hFFFC,
    parameter logic [15:0] IRQ_VECTOR   = 16'hFFFE,
    parameter int          MISS_TIMEOUT = 15,
    parameter int          CNT_W        = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        br_taken,
    input  logic [15:0] br_target,
    input  logic        irq_req,
    input  logic        ins_len2,
    input  logic        dec_stall,
    input  logic        cache_hit,
    input  logic        ir_valid,
    input  logic [15:0] pc_out,
    output logic        pc_w,
    output logic [15:0] pc_alu,
    output logic        pc_inc,
    output logic        pc_i2,
    output logic        pc_inv,
    output logic        hold,
    output logic        irq_ack,
    output logic [15:0] irq_ret_pc,
    output logic        fetch_fault,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        ST_BOOT  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_FILL  = 3'd2,
        ST_RUN   = 3'd3,
        ST_MISS  = 3'd4,
        ST_FAULT = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] c_TIMEOUT = CNT_W'(MISS_TIMEOUT);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_miss_cnt;
    logic [15:0]      r_irq_ret_pc;
    logic             w_adv;
    logic             w_miss_enter;

    assign w_adv = ir_valid & cache_hit & ~dec_stall;

    always_comb begin
        pc_w         = 1'b0;
        pc_alu       = 16'h0000;
        pc_inc       = 1'b0;
        pc_i2        = 1'b0;
        pc_inv       = 1'b0;
        hold         = 1'b0;
        irq_ack      = 1'b0;
        fetch_fault  = 1'b0;
        w_miss_enter = 1'b0;
        w_next       = r_state;
        if (rst) begin
            hold   = 1'b1;
            pc_inv = 1'b1;
            pc_alu = RESET_VECTOR;
            w_next = ST_BOOT;
        end else begin
            case (r_state)
                ST_BOOT: begin
                    hold   = 1'b1;
                    pc_inv = 1'b1;
                    pc_alu = RESET_VECTOR;
                    w_next = ST_LOAD;
                end
                ST_LOAD: begin
                    pc_w   = 1'b1;
                    pc_inv = 1'b1;
                    pc_alu = RESET_VECTOR;
                    w_next = ST_FILL;
                end
                ST_FILL: begin
                    pc_inv = 1'b1;
                    if (br_taken) begin
                        pc_w   = 1'b1;
                        pc_alu = br_target;
                    end else if (cache_hit) begin
                        w_next = ST_RUN;
                    end else begin
                        w_next       = ST_MISS;
                        w_miss_enter = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (br_taken) begin
                        pc_w   = 1'b1;
                        pc_inv = 1'b1;
                        pc_alu = br_target;
                        w_next = ST_FILL;
                    end else if (w_adv && irq_req) begin
                        pc_w    = 1'b1;
                        pc_inv  = 1'b1;
                        pc_alu  = IRQ_VECTOR;
                        irq_ack = 1'b1;
                        w_next  = ST_FILL;
                    end else if (w_adv) begin
                        pc_inc = 1'b1;
                        pc_i2  = ins_len2;
                    end else if (!cache_hit) begin
                        hold         = 1'b1;
                        w_next       = ST_MISS;
                        w_miss_enter = 1'b1;
                    end else begin
                        hold = 1'b1;
                    end
                end
                ST_MISS: begin
                    hold = 1'b1;
                    if (br_taken) begin
                        pc_w   = 1'b1;
                        pc_inv = 1'b1;
                        pc_alu = br_target;
                        w_next = ST_FILL;
                    end else if (cache_hit) begin
                        w_next = ST_RUN;
                    end else if (r_miss_cnt == c_TIMEOUT) begin
                        w_next = ST_FAULT;
                    end
                end
                ST_FAULT: begin
                    hold        = 1'b1;
                    pc_inv      = 1'b1;
                    fetch_fault = 1'b1;
                    if (br_taken) begin
                        pc_w   = 1'b1;
                        pc_alu = br_target;
                        w_next = ST_FILL;
                    end
                end
                default: begin
                    // Unused encodings recover through the boot sequence.
                    hold   = 1'b1;
                    pc_inv = 1'b1;
                    w_next = ST_BOOT;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_BOOT;
            r_miss_cnt   <= '0;
            r_irq_ret_pc <= 16'h0000;
        end else begin
            r_state <= w_next;
            if (w_miss_enter) begin
                r_miss_cnt <= '0;
            end else if (r_state == ST_MISS) begin
                r_miss_cnt <= r_miss_cnt + CNT_W'(1);
            end
            if (irq_ack) begin
                r_irq_ret_pc <= pc_out + (ins_len2 ? 16'd2 : 16'd1);
            end
        end
    end

    // Reset is visible on the outputs in the same cycle it is asserted.
    assign irq_ret_pc = rst ? 16'h0000 : r_irq_ret_pc;
    assign state_dbg  = rst ? 3'd0 : r_state;

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_ctrl
// Brief    : Directed plus randomized bench for fetch_ctrl against a cycle
//            reference model of the sequencing rules.
// Revision : 1.0  initial release
// ============================================================================
module tb_fetch_ctrl;

    localparam logic [15:0] c_RV  = 16'hFFFC;
    localparam logic [15:0] c_IV  = 16'hFFFE;
    localparam int          c_TMO = 15;

    localparam int c_BOOT = 0, c_LOAD = 1, c_FILL = 2, c_RUN = 3, c_MISS = 4, c_FAULT = 5;

    logic        clk = 1'b0;
    logic        rst, br_taken, irq_req, ins_len2, dec_stall, cache_hit, ir_valid;
    logic [15:0] br_target, pc_out;
    logic        pc_w, pc_inc, pc_i2, pc_inv, hold, irq_ack, fetch_fault;
    logic [15:0] pc_alu, irq_ret_pc;
    logic [2:0]  state_dbg;

    int          vectors = 0;
    int          miscompares = 0;

    int          cyc = 0;
    int          m_st = c_BOOT;
    int          m_miss_t0 = 0;
    logic [15:0] m_ret = 16'h0000;

    fetch_ctrl #(
        .RESET_VECTOR(c_RV),
        .IRQ_VECTOR  (c_IV),
        .MISS_TIMEOUT(c_TMO),
        .CNT_W       (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .irq_req    (irq_req),
        .ins_len2   (ins_len2),
        .dec_stall  (dec_stall),
        .cache_hit  (cache_hit),
        .ir_valid   (ir_valid),
        .pc_out     (pc_out),
        .pc_w       (pc_w),
        .pc_alu     (pc_alu),
        .pc_inc     (pc_inc),
        .pc_i2      (pc_i2),
        .pc_inv     (pc_inv),
        .hold       (hold),
        .irq_ack    (irq_ack),
        .irq_ret_pc (irq_ret_pc),
        .fetch_fault(fetch_fault),
        .state_dbg  (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp_v);
        end
    endtask

    // One clock: inputs already driven; predict, compare, advance the model.
    task automatic tick();
        logic        e_w, e_inc, e_i2, e_inv, e_hold, e_ack, e_fault;
        logic [15:0] e_alu, e_ret, ret_next;
        logic [2:0]  e_dbg;
        int          n_st;
        bit          adv, enter_miss;
        #1;
        adv = ir_valid && cache_hit && !dec_stall;
        {e_w, e_inc, e_i2, e_inv, e_hold, e_ack, e_fault} = '0;
        e_alu = 16'h0000;
        e_ret = m_ret;
        e_dbg = 3'(m_st);
        ret_next = m_ret;
        n_st = m_st;
        enter_miss = 0;
        if (rst) begin
            e_hold = 1; e_inv = 1; e_alu = c_RV; e_ret = 16'h0000; e_dbg = 3'd0;
            n_st = c_BOOT; ret_next = 16'h0000;
        end else if (m_st == c_BOOT) begin
            e_hold = 1; e_inv = 1; e_alu = c_RV; n_st = c_LOAD;
        end else if (m_st == c_LOAD) begin
            e_w = 1; e_inv = 1; e_alu = c_RV; n_st = c_FILL;
        end else if (m_st == c_FILL) begin
            e_inv = 1;
            if (br_taken) begin e_w = 1; e_alu = br_target; end
            else if (cache_hit) n_st = c_RUN;
            else begin n_st = c_MISS; enter_miss = 1; end
        end else if (m_st == c_RUN) begin
            if (br_taken) begin
                e_w = 1; e_inv = 1; e_alu = br_target; n_st = c_FILL;
            end else if (adv && irq_req) begin
                e_w = 1; e_inv = 1; e_alu = c_IV; e_ack = 1; n_st = c_FILL;
                ret_next = pc_out + (ins_len2 ? 16'd2 : 16'd1);
            end else if (adv) begin
                e_inc = 1; e_i2 = ins_len2;
            end else if (!cache_hit) begin
                e_hold = 1; n_st = c_MISS; enter_miss = 1;
            end else begin
                e_hold = 1;
            end
        end else if (m_st == c_MISS) begin
            e_hold = 1;
            if (br_taken) begin e_w = 1; e_inv = 1; e_alu = br_target; n_st = c_FILL; end
            else if (cache_hit) n_st = c_RUN;
            else if (cyc - m_miss_t0 == c_TMO) n_st = c_FAULT;
        end else begin
            e_hold = 1; e_inv = 1; e_fault = 1;
            if (br_taken) begin e_w = 1; e_alu = br_target; n_st = c_FILL; end
        end
        chk("pc_w", 16'(pc_w), 16'(e_w));
        chk("pc_alu", pc_alu, e_alu);
        chk("pc_inc", 16'(pc_inc), 16'(e_inc));
        chk("pc_i2", 16'(pc_i2), 16'(e_i2));
        chk("pc_inv", 16'(pc_inv), 16'(e_inv));
        chk("hold", 16'(hold), 16'(e_hold));
        chk("irq_ack", 16'(irq_ack), 16'(e_ack));
        chk("irq_ret_pc", irq_ret_pc, e_ret);
        chk("fetch_fault", 16'(fetch_fault), 16'(e_fault));
        chk("state_dbg", 16'(state_dbg), 16'(e_dbg));
        @(posedge clk);
        if (enter_miss) m_miss_t0 = cyc + 1;
        m_ret = ret_next;
        m_st  = n_st;
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        int hit_pct, br_pct;
        rst = 1; br_taken = 0; br_target = 16'h0000; irq_req = 0; ins_len2 = 0;
        dec_stall = 0; cache_hit = 1; ir_valid = 1; pc_out = 16'h0000;
        @(negedge clk);

        // Reset for two cycles, then boot into RUN.
        tick(); tick();
        rst = 0;
        repeat (4) tick();
        chk("boot_pc_inc", 16'(pc_inc), 16'd1);

        // Advance widths and a 3-cycle decode stall.
        for (int i = 0; i < 4; i++) begin ins_len2 = i[0]; tick(); end
        ins_len2 = 0; dec_stall = 1;
        repeat (3) tick();
        dec_stall = 0;
        tick();

        // Branch in RUN.
        br_taken = 1; br_target = 16'h1234;
        tick();
        br_taken = 0;
        tick(); tick();

        // Interrupt entry with a two-word instruction.
        irq_req = 1; pc_out = 16'h0040; ins_len2 = 1;
        tick();
        irq_req = 0;
        chk("irq_ret_pc_0042", irq_ret_pc, 16'h0042);
        tick(); tick();

        // Branch and interrupt together: branch wins, IRQ stays pending.
        irq_req = 1; br_taken = 1; br_target = 16'h2000;
        tick();
        br_taken = 0;
        tick();
        pc_out = 16'hFFFF;
        tick();
        irq_req = 0; ins_len2 = 0;
        chk("irq_ret_pc_wrap", irq_ret_pc, 16'h0001);
        tick(); tick();

        // Sustained miss runs into FAULT; branch escapes.
        cache_hit = 0;
        repeat (20) tick();
        chk("fault_held", 16'(fetch_fault), 16'd1);
        br_taken = 1; br_target = 16'h0100;
        tick();
        br_taken = 0; cache_hit = 1;
        tick(); tick();

        // Short miss resolved by a hit.
        cache_hit = 0;
        repeat (5) tick();
        cache_hit = 1;
        tick(); tick();

        // Reset while in MISS, then a full-length timeout after re-entry.
        cache_hit = 0;
        repeat (4) tick();
        rst = 1;
        tick();
        rst = 0; cache_hit = 1;
        repeat (3) tick();
        cache_hit = 0;
        repeat (18) tick();
        br_taken = 1; br_target = 16'h0200; cache_hit = 1;
        tick();
        br_taken = 0;
        tick();

        // Randomized traffic in blocks of differing cache behaviour.
        for (int blk = 0; blk < 12; blk++) begin
            case (blk % 3)
                0:       begin hit_pct = 95; br_pct = 8; end
                1:       begin hit_pct = 60; br_pct = 8; end
                default: begin hit_pct = 4;  br_pct = 2; end
            endcase
            for (int i = 0; i < 40; i++) begin
                rst       = ($urandom_range(0, 199) == 0);
                br_taken  = ($urandom_range(0, 99) < br_pct);
                br_target = 16'($urandom);
                irq_req   = ($urandom_range(0, 99) < 25);
                ins_len2  = 1'($urandom);
                dec_stall = ($urandom_range(0, 99) < 20);
                cache_hit = ($urandom_range(0, 99) < hit_pct);
                ir_valid  = ($urandom_range(0, 99) < 90);
                pc_out    = 16'($urandom);
                tick();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
